// File: rtl/multicycle_ctrl.sv
// Control FSM for a multicycle MIPS-style datapath: sequences fetch, decode,
// execute, memory and write-back steps and drives the datapath selects and strobes.
module multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero_flag,
    input  logic       mem_ready,
    output logic [2:0] alu_func,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] debug_state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC_R = 4'd2,
        EXEC_I = 4'd3,
        ADDR   = 4'd4,
        MEM_RD = 4'd5,
        MEM_WR = 4'd6,
        WB_R   = 4'd7,
        WB_I   = 4'd8,
        WB_MEM = 4'd9,
        BRANCH = 4'd10,
        JUMP   = 4'd11,
        TRAP   = 4'd12
    } state_t;

    state_t state, next_state;

    logic       ir_write_raw, pc_write_raw, reg_write_raw, mem_write_raw;
    logic [2:0] r_func;
    logic       r_ok;
    logic [2:0] i_func;
    logic       i_zext;

    // R-type funct to ALU operation; r_ok flags the supported subset.
    always_comb begin
        r_func = 3'd0;
        r_ok   = 1'b1;
        case (funct)
            6'h20, 6'h21: r_func = 3'd0;
            6'h22, 6'h23: r_func = 3'd1;
            6'h24:        r_func = 3'd2;
            6'h25:        r_func = 3'd3;
            6'h27:        r_func = 3'd4;
            6'h26:        r_func = 3'd5;
            6'h2A:        r_func = 3'd6;
            default:      r_ok   = 1'b0;
        endcase
    end

    always_comb begin
        i_func = 3'd0;
        i_zext = 1'b0;
        case (opcode)
            6'h0A:   i_func = 3'd6;
            6'h0C:   begin i_func = 3'd2; i_zext = 1'b1; end
            6'h0D:   begin i_func = 3'd3; i_zext = 1'b1; end
            6'h0E:   begin i_func = 3'd5; i_zext = 1'b1; end
            6'h0F:   i_func = 3'd7;
            default: i_func = 3'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (next_state == TRAP)
                illegal <= 1'b1;
        end
    end

    always_comb begin
        next_state    = state;
        alu_func      = 3'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        imm_zext      = 1'b0;
        mem_read      = 1'b0;
        mem_write_raw = 1'b0;
        iord          = 1'b0;
        ir_write_raw  = 1'b0;
        pc_write_raw  = 1'b0;
        pc_src        = 2'd0;
        reg_write_raw = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_write_raw = 1'b1;
                    pc_write_raw = 1'b1;
                    next_state   = DECODE;
                end
            end
            DECODE: begin
                // PC + (imm << 2) is parked in ALUOut for a possible branch.
                alu_src_b = 2'd3;
                case (opcode)
                    6'h00:        next_state = r_ok ? EXEC_R : TRAP;
                    6'h23, 6'h2B: next_state = ADDR;
                    6'h04, 6'h05: next_state = BRANCH;
                    6'h02:        next_state = JUMP;
                    6'h08, 6'h09, 6'h0A, 6'h0C,
                    6'h0D, 6'h0E, 6'h0F: next_state = EXEC_I;
                    default:      next_state = TRAP;
                endcase
            end
            EXEC_R: begin
                alu_src_a  = 1'b1;
                alu_func   = r_func;
                next_state = WB_R;
            end
            EXEC_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                alu_func   = i_func;
                imm_zext   = i_zext;
                next_state = WB_I;
            end
            ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'd2;
                next_state = (opcode == 6'h2B) ? MEM_WR : MEM_RD;
            end
            MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)
                    next_state = WB_MEM;
            end
            MEM_WR: begin
                mem_write_raw = 1'b1;
                iord          = 1'b1;
                if (mem_ready)
                    next_state = FETCH;
            end
            WB_R: begin
                reg_write_raw = 1'b1;
                reg_dst       = 1'b1;
                next_state    = FETCH;
            end
            WB_I: begin
                reg_write_raw = 1'b1;
                next_state    = FETCH;
            end
            WB_MEM: begin
                reg_write_raw = 1'b1;
                mem_to_reg    = 1'b1;
                next_state    = FETCH;
            end
            BRANCH: begin
                alu_src_a    = 1'b1;
                alu_func     = 3'd1;
                pc_src       = 2'd1;
                pc_write_raw = (opcode == 6'h05) ? !zero_flag : zero_flag;
                next_state   = FETCH;
            end
            JUMP: begin
                pc_src       = 2'd2;
                pc_write_raw = 1'b1;
                next_state   = FETCH;
            end
            TRAP:    next_state = TRAP;
            default: next_state = FETCH;
        endcase
    end

    // Architectural write enables are held off while reset is asserted.
    assign ir_write    = ir_write_raw  & rst_n;
    assign pc_write    = pc_write_raw  & rst_n;
    assign reg_write   = reg_write_raw & rst_n;
    assign mem_write   = mem_write_raw & rst_n;
    assign debug_state = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle
// and compares every control output against hand-written expectations.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero_flag, mem_ready;
    logic [2:0] alu_func;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext, mem_read, mem_write, iord, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write, reg_dst, mem_to_reg, illegal;
    logic [3:0] debug_state;
    logic [17:0] ctl;

    int errors = 0;
    int checks = 0;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2,
        S_EXEC_I = 4'd3, S_ADDR = 4'd4, S_MEM_RD = 4'd5, S_MEM_WR = 4'd6,
        S_WB_R = 4'd7, S_WB_I = 4'd8, S_WB_MEM = 4'd9, S_BRANCH = 4'd10,
        S_JUMP = 4'd11, S_TRAP = 4'd12;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
        .zero_flag(zero_flag), .mem_ready(mem_ready),
        .alu_func(alu_func), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_zext(imm_zext), .mem_read(mem_read), .mem_write(mem_write),
        .iord(iord), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .debug_state(debug_state)
    );

    always #5 clk = ~clk;

    assign ctl = {alu_func, alu_src_a, alu_src_b, imm_zext, mem_read, mem_write, iord,
                  ir_write, pc_write, pc_src, reg_write, reg_dst, mem_to_reg, illegal};

    // mem = {mem_read, mem_write, iord}; pc = {ir_write, pc_write, pc_src};
    // wb = {reg_write, reg_dst, mem_to_reg}
    function automatic logic [17:0] mk(input logic [2:0] f, input logic a, input logic [1:0] b,
                                       input logic z, input logic [2:0] mem,
                                       input logic [3:0] pc, input logic [2:0] wb,
                                       input logic il);
        return {f, a, b, z, mem, pc, wb, il};
    endfunction

    localparam logic [17:0] F_RDY  = {3'd0, 1'b0, 2'd1, 1'b0, 3'b100, 4'b1100, 3'b000, 1'b0};
    localparam logic [17:0] F_WAIT = {3'd0, 1'b0, 2'd1, 1'b0, 3'b100, 4'b0000, 3'b000, 1'b0};
    localparam logic [17:0] DEC    = {3'd0, 1'b0, 2'd3, 1'b0, 3'b000, 4'b0000, 3'b000, 1'b0};
    localparam logic [17:0] WBR    = {3'd0, 1'b0, 2'd0, 1'b0, 3'b000, 4'b0000, 3'b110, 1'b0};
    localparam logic [17:0] WBI    = {3'd0, 1'b0, 2'd0, 1'b0, 3'b000, 4'b0000, 3'b100, 1'b0};
    localparam logic [17:0] WBM    = {3'd0, 1'b0, 2'd0, 1'b0, 3'b000, 4'b0000, 3'b101, 1'b0};
    localparam logic [17:0] ADR    = {3'd0, 1'b1, 2'd2, 1'b0, 3'b000, 4'b0000, 3'b000, 1'b0};
    localparam logic [17:0] MRD    = {3'd0, 1'b0, 2'd0, 1'b0, 3'b101, 4'b0000, 3'b000, 1'b0};
    localparam logic [17:0] MWR    = {3'd0, 1'b0, 2'd0, 1'b0, 3'b011, 4'b0000, 3'b000, 1'b0};
    localparam logic [17:0] JMP    = {3'd0, 1'b0, 2'd0, 1'b0, 3'b000, 4'b0110, 3'b000, 1'b0};
    localparam logic [17:0] TRP    = {3'd0, 1'b0, 2'd0, 1'b0, 3'b000, 4'b0000, 3'b000, 1'b1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: apply inputs, check outputs and state, advance past the next edge.
    task automatic cyc(input string tag, input logic mr, input logic zf,
                       input logic [17:0] e, input logic [3:0] st);
        mem_ready = mr;
        zero_flag = zf;
        #1;
        check(tag, {14'd0, ctl}, {14'd0, e});
        check({tag, "_st"}, {28'd0, debug_state}, {28'd0, st});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check({tag, "_async"}, {14'd0, ctl}, {14'd0, F_WAIT});
        check({tag, "_async_st"}, {28'd0, debug_state}, {28'd0, S_FETCH});
        @(posedge clk);
        #1;
        check({tag, "_held"}, {14'd0, ctl}, {14'd0, F_WAIT});
        rst_n = 1'b1;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
        opcode = op;
        funct  = fn;
    endtask

    initial begin
        opcode = 6'h00; funct = 6'h20; zero_flag = 1'b0; mem_ready = 1'b1; rst_n = 1'b0;
        do_reset("por");

        set_instr(6'h00, 6'h20);
        cyc("add_fetch", 1'b1, 1'b0, F_RDY, S_FETCH);
        cyc("add_dec",   1'b1, 1'b0, DEC, S_DECODE);
        cyc("add_exec",  1'b1, 1'b0, mk(3'd0, 1'b1, 2'd0, 1'b0, 3'b000, 4'b0000, 3'b000, 1'b0), S_EXEC_R);
        cyc("add_wb",    1'b1, 1'b0, WBR, S_WB_R);

        set_instr(6'h00, 6'h22);
        cyc("sub_stall", 1'b0, 1'b0, F_WAIT, S_FETCH);
        cyc("sub_fetch", 1'b1, 1'b0, F_RDY, S_FETCH);
        cyc("sub_dec",   1'b0, 1'b0, DEC, S_DECODE);
        cyc("sub_exec",  1'b0, 1'b0, mk(3'd1, 1'b1, 2'd0, 1'b0, 3'b000, 4'b0000, 3'b000, 1'b0), S_EXEC_R);
        cyc("sub_wb",    1'b0, 1'b0, WBR, S_WB_R);

        set_instr(6'h23, 6'h00);
        cyc("lw_fetch", 1'b1, 1'b0, F_RDY, S_FETCH);
        cyc("lw_dec",   1'b1, 1'b0, DEC, S_DECODE);
        cyc("lw_addr",  1'b1, 1'b0, ADR, S_ADDR);
        for (int i = 0; i < 3; i++)
            cyc("lw_memrd_wait", 1'b0, 1'b0, MRD, S_MEM_RD);
        cyc("lw_memrd", 1'b1, 1'b0, MRD, S_MEM_RD);
        cyc("lw_wb",    1'b1, 1'b0, WBM, S_WB_MEM);

        set_instr(6'h2B, 6'h00);
        cyc("sw_fetch", 1'b1, 1'b0, F_RDY, S_FETCH);
        cyc("sw_dec",   1'b1, 1'b0, DEC, S_DECODE);
        cyc("sw_addr",  1'b1, 1'b0, ADR, S_ADDR);
        cyc("sw_memwr", 1'b1, 1'b0, MWR, S_MEM_WR);

        for (int k = 0; k < 4; k++) begin
            logic zf;
            logic taken;
            zf = (k % 2 == 0);
            set_instr((k < 2) ? 6'h04 : 6'h05, 6'h00);
            taken = (k < 2) ? zf : !zf;
            cyc("br_fetch", 1'b1, 1'b0, F_RDY, S_FETCH);
            cyc("br_dec",   1'b1, 1'b0, DEC, S_DECODE);
            cyc((k < 2) ? "beq_exec" : "bne_exec", 1'b1, zf,
                mk(3'd1, 1'b1, 2'd0, 1'b0, 3'b000, {1'b0, taken, 2'd1}, 3'b000, 1'b0), S_BRANCH);
        end

        set_instr(6'h02, 6'h00);
        cyc("j_fetch", 1'b1, 1'b0, F_RDY, S_FETCH);
        cyc("j_dec",   1'b1, 1'b0, DEC, S_DECODE);
        cyc("j_exec",  1'b1, 1'b0, JMP, S_JUMP);

        set_instr(6'h0D, 6'h00);
        cyc("ori_fetch", 1'b1, 1'b0, F_RDY, S_FETCH);
        cyc("ori_dec",   1'b1, 1'b0, DEC, S_DECODE);
        cyc("ori_exec",  1'b1, 1'b0, mk(3'd3, 1'b1, 2'd2, 1'b1, 3'b000, 4'b0000, 3'b000, 1'b0), S_EXEC_I);
        cyc("ori_wb",    1'b1, 1'b0, WBI, S_WB_I);

        set_instr(6'h0F, 6'h00);
        cyc("lui_fetch", 1'b1, 1'b0, F_RDY, S_FETCH);
        cyc("lui_dec",   1'b1, 1'b0, DEC, S_DECODE);
        cyc("lui_exec",  1'b1, 1'b0, mk(3'd7, 1'b1, 2'd2, 1'b0, 3'b000, 4'b0000, 3'b000, 1'b0), S_EXEC_I);
        cyc("lui_wb",    1'b1, 1'b0, WBI, S_WB_I);

        set_instr(6'h0A, 6'h00);
        cyc("slti_fetch", 1'b1, 1'b0, F_RDY, S_FETCH);
        cyc("slti_dec",   1'b1, 1'b0, DEC, S_DECODE);
        cyc("slti_exec",  1'b1, 1'b0, mk(3'd6, 1'b1, 2'd2, 1'b0, 3'b000, 4'b0000, 3'b000, 1'b0), S_EXEC_I);
        cyc("slti_wb",    1'b1, 1'b0, WBI, S_WB_I);

        set_instr(6'h00, 6'h26);
        cyc("xor_fetch", 1'b1, 1'b0, F_RDY, S_FETCH);
        cyc("xor_dec",   1'b1, 1'b0, DEC, S_DECODE);
        cyc("xor_exec",  1'b1, 1'b0, mk(3'd5, 1'b1, 2'd0, 1'b0, 3'b000, 4'b0000, 3'b000, 1'b0), S_EXEC_R);
        cyc("xor_wb",    1'b1, 1'b0, WBR, S_WB_R);

        // Reset pulsed in the middle of a stalled store.
        set_instr(6'h2B, 6'h00);
        cyc("swr_fetch", 1'b1, 1'b0, F_RDY, S_FETCH);
        cyc("swr_dec",   1'b1, 1'b0, DEC, S_DECODE);
        cyc("swr_addr",  1'b1, 1'b0, ADR, S_ADDR);
        mem_ready = 1'b0;
        #1;
        check("swr_memwr", {14'd0, ctl}, {14'd0, MWR});
        #2;
        rst_n = 1'b0;
        #1;
        check("swr_rst_mw", {31'd0, mem_write}, 32'd0);
        check("swr_rst_ctl", {14'd0, ctl}, {14'd0, F_WAIT});
        check("swr_rst_st", {28'd0, debug_state}, {28'd0, S_FETCH});
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        set_instr(6'h3F, 6'h00);
        cyc("bad_op_fetch", 1'b1, 1'b0, F_RDY, S_FETCH);
        cyc("bad_op_dec",   1'b1, 1'b0, DEC, S_DECODE);
        for (int i = 0; i < 20; i++)
            cyc("bad_op_trap", i[0], i[1], TRP, S_TRAP);
        do_reset("trap_rst");
        check("trap_rst_ill", {31'd0, illegal}, 32'd0);

        set_instr(6'h00, 6'h00);
        cyc("bad_fn_fetch", 1'b1, 1'b0, F_RDY, S_FETCH);
        cyc("bad_fn_dec",   1'b1, 1'b0, DEC, S_DECODE);
        for (int i = 0; i < 3; i++)
            cyc("bad_fn_trap", 1'b1, 1'b0, TRP, S_TRAP);
        do_reset("trap2_rst");

        set_instr(6'h00, 6'h20);
        cyc("post_fetch", 1'b1, 1'b0, F_RDY, S_FETCH);
        cyc("post_dec",   1'b1, 1'b0, DEC, S_DECODE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
